adc_sample_averager: RTL

ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

---
 rtl/adc_sample_averager.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/adc_sample_averager.sv
// ADC sample averager: accumulates 2**LOG2_N samples from one ADC channel,
// removes a fixed offset, saturates into [0, OUT_MAX] and hands the result
// downstream over a valid/ready port while tracking min/max and overruns.
//
// Handshake: out_valid is raised when a result is loaded and stays high,
// with out_data/out_clamp_* frozen, until a clock edge sees out_valid=1 and
// out_ready=1 (one transfer). out_valid never depends combinationally on
// out_ready. A result that finishes while the port is stalled is dropped and
// counted in overrun_cnt; the held result keeps its place.
module adc_sample_averager #(
  parameter logic [4:0]  CHANNEL = 5'd17,
  parameter logic [11:0] OFFSET  = 12'd3431,
  parameter int          LOG2_N  = 4,
  parameter logic [8:0]  OUT_MAX = 9'd511
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        rsp_valid,
  input  logic [4:0]  rsp_channel,
  input  logic [11:0] rsp_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [8:0]  out_data,
  output logic        out_clamp_lo,
  output logic        out_clamp_hi,
  output logic [8:0]  min_data,
  output logic [8:0]  max_data,
  output logic [7:0]  overrun_cnt,
  output logic        fsm_state
);

  localparam int ACC_W = 12 + LOG2_N;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [LOG2_N-1:0]   cnt;
  logic                take;
  logic                last;
  logic                new_res;
  logic                xfer;
  logic                load;
  logic [11:0]         avg;
  logic signed [13:0]  diff;
  logic [8:0]          res_data;
  logic                res_lo;
  logic                res_hi;

  assign fsm_state = state;

  // State register; reset forces IDLE.
  always_ff @(posedge clock_in) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and sample qualification. Samples are only taken while
  // ACCUM and still enabled, so a falling enable never finishes an average.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nx = ACCUM;
      end
      ACCUM: begin
        if (!enable) state_nx = IDLE;
        else         take = rsp_valid && (rsp_channel == CHANNEL);
      end
      default: state_nx = IDLE;
    endcase
  end

  assign last    = &cnt;
  assign new_res = take && last;
  assign sum     = acc + ACC_W'(rsp_data);
  assign avg     = 12'(sum >> LOG2_N);
  assign diff    = $signed({2'b00, avg}) - $signed({2'b00, OFFSET});
  assign xfer    = out_valid && out_ready;
  assign load    = new_res && (!out_valid || out_ready);

  // Offset correction and saturation into the 9-bit output range.
  always_comb begin
    res_data = diff[8:0];
    res_lo   = 1'b0;
    res_hi   = 1'b0;
    if (diff < 14'sd0) begin
      res_data = 9'd0;
      res_lo   = 1'b1;
    end else if (diff > $signed({5'b00000, OUT_MAX})) begin
      res_data = OUT_MAX;
      res_hi   = 1'b1;
    end
  end

  // Accumulator and sample counter; cleared outside ACCUM, on enable loss
  // and on the final sample of each average.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end else if (state != ACCUM || !enable) begin
      acc <= '0;
      cnt <= '0;
    end
  end

  // Output holding register and handshake.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_clamp_lo <= 1'b0;
      out_clamp_hi <= 1'b0;
    end else if (load) begin
      out_valid    <= 1'b1;
      out_data     <= res_data;
      out_clamp_lo <= res_lo;
      out_clamp_hi <= res_hi;
    end else if (xfer) begin
      out_valid    <= 1'b0;
    end
  end

  // Extremes of transferred results and saturating overrun counter.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      min_data    <= OUT_MAX;
      max_data    <= '0;
      overrun_cnt <= '0;
    end else begin
      if (xfer) begin
        if (out_data < min_data) min_data <= out_data;
        if (out_data > max_data) max_data <= out_data;
      end
      if (new_res && !load && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule
